// File: rtl/io_stall_controller.sv
// ---------------------------------------------------------------------------
// io_stall_controller
//   Stalls the CPU core on IN, OUT and HLT opcodes by dropping a synchronous
//   clock enable until the matching device handshake completes, then gives
//   exactly one enabled RELEASE cycle so the stalled instruction retires.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   operation/op_valid  opcode currently in decode
//   cpu_data            register value for OUT
//   in_valid/in_data    input device confirm (level) and data
//   out_ready           output device accepted out_data
//   resume              resume request after HLT (level)
//   cpu_enable          core clock enable (combinational)
//   in_data_q/in_ack    latched input value and its 1-cycle strobe
//   out_valid/out_data  output handshake towards the display
//   halted              high while halted
//   io_timeout          sticky wait-timeout flag
//
// Build option
//   IO_TIMEOUT_EN  when defined, IN/OUT waits give up after TIMEOUT_CYCLES
//                  wait cycles and set io_timeout; otherwise waits are
//                  unbounded and io_timeout is tied low.
// ---------------------------------------------------------------------------
module io_stall_controller #(
    parameter int             DATA_WIDTH     = 32,
    parameter logic [5:0]     OP_IN          = 6'b011101,
    parameter logic [5:0]     OP_OUT_A       = 6'b011110,
    parameter logic [5:0]     OP_OUT_B       = 6'b100000,
    parameter logic [5:0]     OP_HLT         = 6'b011100,
    parameter int             TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            operation,
    input  logic                  op_valid,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    input  logic                  resume,
    output logic                  cpu_enable,
    output logic [DATA_WIDTH-1:0] in_data_q,
    output logic                  in_ack,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  halted,
    output logic                  io_timeout
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        IN_WAIT  = 3'd1,
        OUT_WAIT = 3'd2,
        HALT     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    // The wait counter needs at least one bit.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t state, state_nxt;

    logic is_in, is_out, is_hlt, trig;
    logic in_valid_prev, resume_prev;
    logic in_rise, resume_rise;
    logic timeout_hit;

    assign is_in  = (operation == OP_IN);
    assign is_out = (operation == OP_OUT_A) || (operation == OP_OUT_B);
    assign is_hlt = (operation == OP_HLT);
    assign trig   = op_valid && (is_in || is_out || is_hlt);

    // Previous-sample registers reset to 1, so a level already high when
    // reset releases (or before a wait is entered) never counts as an edge.
    assign in_rise     = in_valid && !in_valid_prev;
    assign resume_rise = resume && !resume_prev;

    // Stall starts in the same cycle the opcode shows up in decode.
    assign cpu_enable = ((state == RUN) && !trig) || (state == RELEASE);

`ifdef IO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting, handshake;

    assign waiting     = (state == IN_WAIT) || (state == OUT_WAIT);
    assign handshake   = ((state == IN_WAIT) && in_rise) ||
                         ((state == OUT_WAIT) && out_ready);
    // A handshake in the final wait cycle wins over the timeout.
    assign timeout_hit = waiting && !handshake &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            io_timeout <= 1'b0;
        end else begin
            if (waiting) wait_cnt <= wait_cnt + 1'b1;
            else         wait_cnt <= '0;   // cleared before any wait entry
            if (timeout_hit) io_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign io_timeout  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (trig) begin
                    if (is_in)       state_nxt = IN_WAIT;
                    else if (is_out) state_nxt = OUT_WAIT;
                    else             state_nxt = HALT;
                end
            end
            IN_WAIT:  if (in_rise || timeout_hit)   state_nxt = RELEASE;
            OUT_WAIT: if (out_ready || timeout_hit) state_nxt = RELEASE;
            HALT:     if (resume_rise)              state_nxt = RELEASE;
            RELEASE:  state_nxt = RUN;   // op_valid ignored: no re-trigger
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_valid_prev <= 1'b1;
            resume_prev   <= 1'b1;
            in_data_q     <= '0;
            in_ack        <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            halted        <= 1'b0;
        end else begin
            in_valid_prev <= in_valid;
            resume_prev   <= resume;
            in_ack        <= 1'b0;
            case (state)
                RUN: begin
                    if (trig && is_out) begin
                        out_data  <= cpu_data;
                        out_valid <= 1'b1;
                    end
                    if (trig && is_hlt) halted <= 1'b1;
                end
                IN_WAIT: begin
                    if (in_rise) begin
                        in_data_q <= in_data;
                        in_ack    <= 1'b1;
                    end
                end
                OUT_WAIT: if (out_ready || timeout_hit) out_valid <= 1'b0;
                HALT:     if (resume_rise) halted <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_stall_controller.sv
module tb_io_stall_controller;

    localparam logic [5:0] OPI  = 6'b011101;
    localparam logic [5:0] OPOA = 6'b011110;
    localparam logic [5:0] OPOB = 6'b100000;
    localparam logic [5:0] OPH  = 6'b011100;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  operation;
    logic        op_valid;
    logic [31:0] cpu_data;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        resume;
    logic        cpu_enable;
    logic [31:0] in_data_q;
    logic        in_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic        halted;
    logic        io_timeout;

    int checks = 0;
    int errors = 0;

    io_stall_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .operation(operation), .op_valid(op_valid),
        .cpu_data(cpu_data), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .resume(resume), .cpu_enable(cpu_enable),
        .in_data_q(in_data_q), .in_ack(in_ack), .out_valid(out_valid),
        .out_data(out_data), .halted(halted), .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    // One row = one clock cycle: inputs held that cycle, outputs expected
    // during that same cycle (registered ones reflect earlier edges).
    typedef struct {
        logic        ov;
        logic [5:0]  op;
        logic [31:0] cd;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        res;
        logic        ce;
        logic        ack;
        logic        ovld;
        logic [31:0] od;
        logic        hlt;
        logic [31:0] idq;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic cyc(input logic ov, input logic [5:0] op, input logic [31:0] cd,
                       input logic iv, input logic [31:0] id, input logic ordy,
                       input logic res);
        @(negedge clock);
        op_valid = ov; operation = op; cpu_data = cd;
        in_valid = iv; in_data = id; out_ready = ordy; resume = res;
        #1;
    endtask

    localparam logic [31:0] DIN = 32'hA5A5_0001;

    initial begin
        //            ov op    cd     iv id   ordy res | ce ack ovld od     hlt idq
        // reset then harmless opcode
        tbl[0]  = '{1'b1, 6'h00, 32'h0, 0, 0,   0, 0,   1, 0, 0, 32'h0,  0, 32'h0};
        // IN: 6 stall cycles, in_valid rises 5 cycles after the opcode
        tbl[1]  = '{1'b1, OPI,   32'h0, 0, 0,   0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        tbl[2]  = '{1'b0, OPI,   32'h0, 0, 0,   0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        tbl[3]  = '{1'b0, OPI,   32'h0, 0, 0,   0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        tbl[4]  = '{1'b0, OPI,   32'h0, 0, 0,   0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        tbl[5]  = '{1'b0, OPI,   32'h0, 0, 0,   0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        tbl[6]  = '{1'b0, OPI,   32'h0, 1, DIN, 0, 0,   0, 0, 0, 32'h0,  0, 32'h0};
        // RELEASE with the same opcode still offered: must not re-trigger
        tbl[7]  = '{1'b1, OPI,   32'h0, 1, DIN, 0, 0,   1, 1, 0, 32'h0,  0, DIN};
        tbl[8]  = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 0,   1, 0, 0, 32'h0,  0, DIN};
        // OUT_B with out_ready already high: one OUT_WAIT cycle
        tbl[9]  = '{1'b1, OPOB,  32'hFF,0, 0,   1, 0,   0, 0, 0, 32'h0,  0, DIN};
        tbl[10] = '{1'b0, 6'h00, 32'h0, 0, 0,   1, 0,   0, 0, 1, 32'hFF, 0, DIN};
        tbl[11] = '{1'b0, 6'h00, 32'h0, 0, 0,   1, 0,   1, 0, 0, 32'hFF, 0, DIN};
        tbl[12] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 0,   1, 0, 0, 32'hFF, 0, DIN};
        // HLT with resume already high: stays halted until a fresh edge
        tbl[13] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 1,   1, 0, 0, 32'hFF, 0, DIN};
        tbl[14] = '{1'b1, OPH,   32'h0, 0, 0,   0, 1,   0, 0, 0, 32'hFF, 0, DIN};
        tbl[15] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 1,   0, 0, 0, 32'hFF, 1, DIN};
        tbl[16] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 1,   0, 0, 0, 32'hFF, 1, DIN};
        tbl[17] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 0,   0, 0, 0, 32'hFF, 1, DIN};
        tbl[18] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 1,   0, 0, 0, 32'hFF, 1, DIN};
        tbl[19] = '{1'b1, OPH,   32'h0, 0, 0,   0, 1,   1, 0, 0, 32'hFF, 0, DIN};
        tbl[20] = '{1'b0, 6'h00, 32'h0, 0, 0,   0, 0,   1, 0, 0, 32'hFF, 0, DIN};

        op_valid = 0; operation = 0; cpu_data = 0; in_valid = 0; in_data = 0;
        out_ready = 0; resume = 0;

        // Reset held 3 cycles
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_cpu_enable", -1, 32'(cpu_enable), 32'd1);
        chk("reset_out_valid",  -1, 32'(out_valid),  32'd0);
        chk("reset_halted",     -1, 32'(halted),     32'd0);
        chk("reset_in_data_q",  -1, in_data_q,       32'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].ov, tbl[i].op, tbl[i].cd, tbl[i].iv, tbl[i].id,
                tbl[i].ordy, tbl[i].res);
            chk("cpu_enable", i, 32'(cpu_enable), 32'(tbl[i].ce));
            chk("in_ack",     i, 32'(in_ack),     32'(tbl[i].ack));
            chk("out_valid",  i, 32'(out_valid),  32'(tbl[i].ovld));
            chk("out_data",   i, out_data,        tbl[i].od);
            chk("halted",     i, 32'(halted),     32'(tbl[i].hlt));
            chk("in_data_q",  i, in_data_q,       tbl[i].idq);
            chk("io_timeout", i, 32'(io_timeout), 32'd0);
        end

        // Reset in the middle of OUT_WAIT aborts asynchronously
        cyc(1, OPOA, 32'h1234, 0, 0, 0, 0);
        chk("rst_seq_trig_ce", 100, 32'(cpu_enable), 32'd0);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("rst_seq_ovld", 101, 32'(out_valid), 32'd1);
        chk("rst_seq_od",   101, out_data, 32'h1234);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("rst_seq_hold_ovld", 102, 32'(out_valid), 32'd1);
        chk("rst_seq_hold_ce",   102, 32'(cpu_enable), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_ovld", 103, 32'(out_valid), 32'd0);
        chk("rst_async_ce",   103, 32'(cpu_enable), 32'd1);
        chk("rst_async_od",   103, out_data, 32'd0);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rst_release_ce", 104, 32'(cpu_enable), 32'd1);

        // Back-to-back OUT_A: two separate handshakes
        cyc(1, OPOA, 32'hAAAA, 0, 0, 0, 0);
        chk("b2b_c0_ce", 110, 32'(cpu_enable), 32'd0);
        cyc(1, OPOA, 32'hBBBB, 0, 0, 0, 0);
        chk("b2b_c1_ovld", 111, 32'(out_valid), 32'd1);
        chk("b2b_c1_od",   111, out_data, 32'hAAAA);
        cyc(1, OPOA, 32'hBBBB, 0, 0, 1, 0);
        chk("b2b_c2_ovld", 112, 32'(out_valid), 32'd1);
        chk("b2b_c2_ce",   112, 32'(cpu_enable), 32'd0);
        cyc(1, OPOA, 32'hBBBB, 0, 0, 0, 0);
        chk("b2b_c3_release_ce", 113, 32'(cpu_enable), 32'd1);
        chk("b2b_c3_ovld",       113, 32'(out_valid), 32'd0);
        cyc(1, OPOA, 32'hBBBB, 0, 0, 0, 0);
        chk("b2b_c4_ce",   114, 32'(cpu_enable), 32'd0);
        chk("b2b_c4_ovld", 114, 32'(out_valid), 32'd0);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("b2b_c5_ovld", 115, 32'(out_valid), 32'd1);
        chk("b2b_c5_od",   115, out_data, 32'hBBBB);
        cyc(0, 6'h00, 32'h0, 0, 0, 1, 0);
        chk("b2b_c6_ovld", 116, 32'(out_valid), 32'd1);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("b2b_c7_ce",   117, 32'(cpu_enable), 32'd1);
        chk("b2b_c7_ovld", 117, 32'(out_valid), 32'd0);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);

`ifdef IO_TIMEOUT_EN
        // Handshake landing in the last wait cycle beats the timeout
        cyc(1, OPI, 32'h0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
            chk("race_wait_ce", 120 + k, 32'(cpu_enable), 32'd0);
        end
        cyc(0, 6'h00, 32'h0, 1, 32'h5555_0001, 0, 0);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("race_release_ce", 129, 32'(cpu_enable), 32'd1);
        chk("race_ack",        129, 32'(in_ack), 32'd1);
        chk("race_no_timeout", 129, 32'(io_timeout), 32'd0);
        chk("race_idq",        129, in_data_q, 32'h5555_0001);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);

        // No in_valid: timeout after 8 wait cycles
        cyc(1, OPI, 32'h0, 0, 0, 0, 0);
        chk("to_trig_ce", 130, 32'(cpu_enable), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
            chk("to_wait_ce",  130 + k, 32'(cpu_enable), 32'd0);
            chk("to_wait_ack", 130 + k, 32'(in_ack), 32'd0);
        end
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("to_release_ce", 139, 32'(cpu_enable), 32'd1);
        chk("to_flag",       139, 32'(io_timeout), 32'd1);
        chk("to_no_ack",     139, 32'(in_ack), 32'd0);
        chk("to_idq_kept",   139, in_data_q, 32'h5555_0001);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("to_run_ce",     140, 32'(cpu_enable), 32'd1);
        chk("to_sticky",     140, 32'(io_timeout), 32'd1);
`else
        // Without the timeout, the wait is unbounded
        cyc(1, OPI, 32'h0, 0, 0, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
            chk("nto_wait_ce", 130 + k, 32'(cpu_enable), 32'd0);
        end
        chk("nto_flag", 161, 32'(io_timeout), 32'd0);
        cyc(0, 6'h00, 32'h0, 1, 32'h0BAD_F00D, 0, 0);
        cyc(0, 6'h00, 32'h0, 1, 32'h0, 0, 0);
        chk("nto_release_ce", 162, 32'(cpu_enable), 32'd1);
        chk("nto_ack",        162, 32'(in_ack), 32'd1);
        chk("nto_idq",        162, in_data_q, 32'h0BAD_F00D);
        cyc(0, 6'h00, 32'h0, 0, 0, 0, 0);
        chk("nto_run_ce",     163, 32'(cpu_enable), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
